mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Sequences the RISC-SPM Address_Register and the shared memory port.
//  Two requesters are served: instruction fetch (IF, from PC) and data (DT, from execute).
//  Arbitrates between them, muxes the winning address into the Address_Register and pulses its load.
//  Then drives the memory read/write strobes and waits for mem_ready; a timeout guards the wait.
// PARAMETERS
//  WORD_SIZE   8   address/data width; must match Address_Register WORD_SIZE
//  TIMEOUT     15  max ACCESS cycles waiting for mem_ready before error; >=1
//  TO_W        4   timeout counter width; must satisfy 2**TO_W > TIMEOUT
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-low reset
//  if_req     in   1          fetch request, level, held until if_done
//  if_addr    in   WORD_SIZE  fetch address (PC)
//  dt_req     in   1          data request, level, held until dt_done
//  dt_we      in   1          1=write, 0=read; sampled at grant
//  dt_addr    in   WORD_SIZE  data address
//  dt_wdata   in   WORD_SIZE  write data; sampled at grant
//  ar_data    out  WORD_SIZE  to Address_Register data_in
//  ar_load    out  1          to Address_Register load
//  mem_rd     out  1          memory read strobe
//  mem_wr     out  1          memory write strobe
//  mem_wdata  out  WORD_SIZE  registered write data
//  mem_ready  in   1          memory completion, sampled in ACCESS only
//  mem_rdata  in   WORD_SIZE  memory read data, valid with mem_ready
//  rdata      out  WORD_SIZE  captured read data, held until next capture
//  if_done    out  1          1-cycle pulse: fetch complete
//  dt_done    out  1          1-cycle pulse: data access complete
//  err        out  1          1-cycle pulse with done: transaction timed out
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, every output 0, rdata=0, last_grant=DT, so IF wins the first tie.
//  - FSM: IDLE -> LOAD -> ACCESS -> DONE -> IDLE. Each state is one cycle, except ACCESS.
//  - IDLE: on any request, grant one requester and latch owner, dt_we and dt_wdata, then go to LOAD.
//    Both requesting: grant the requester not in last_grant (round robin).
//  - LOAD: ar_load=1; ar_data = owner's address, sampled live (requester must hold it).
//    ar_data=0 outside LOAD. The Address_Register output is valid from the ACCESS cycle.
//  - ACCESS: mem_rd=1 (IF, or DT read) or mem_wr=1 (DT write), held every cycle in ACCESS.
//    mem_wdata valid throughout. Timeout counter increments each cycle.
//    If mem_ready=1: capture rdata<=mem_rdata on reads; writes leave rdata unchanged. Go to DONE.
//    If counter reaches TIMEOUT with no mem_ready: set err flag, go to DONE, rdata unchanged.
//  - DONE: strobes 0; owner's done pulses; err pulses if flagged; last_grant<=owner.
//    Clear the counter and err flag, return to IDLE.
//  - Latency: request seen in IDLE at cycle N -> ar_load at N+1 -> strobe from N+2.
//    mem_ready at N+2+k -> done at N+3+k. Zero-wait memory = 4 cycles per transaction.
//  - Back-to-back: IDLE is visited between transactions, giving 1 idle cycle minimum.
//  - A request dropped mid-transaction is ignored: the transaction completes and done still pulses.
//  - A non-owner request arriving mid-transaction waits; it is evaluated in the next IDLE.
//  - mem_rd and mem_wr are never both 1. Only one done pulses per transaction.
//  - mem_ready outside ACCESS is ignored.
//  - rst asserted mid-transaction aborts immediately to reset values; no done or err pulses.
// STRUCTURE
//  - Shared include risc_spm_defs.vh holds the state encodings (IDLE/LOAD/ACCESS/DONE)
//    and the requester IDs (REQ_IF=0, REQ_DT=1).
//  - Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], last_grant -> grant).
//  - FSM, address mux, timeout counter and data registers stay in mem_access_ctrl.
//  - Instantiated with Address_Register #(WORD_SIZE): ar_data->data_in, ar_load->load.
// TESTING
//  1 Reset: rst=0 at 12ns -> all outputs 0 at once.
//    Release; if_req=1, if_addr=8'h10 -> ar_load at N+1 with ar_data=8'h10.
//    mem_rd from N+2; mem_ready at N+2 with rdata 8'hAA -> if_done at N+3, rdata=8'hAA.
//  2 DT write: dt_req=1, dt_we=1, dt_addr=8'h55, dt_wdata=8'h3C, mem_ready after 3 wait cycles
//    -> mem_wr high 4 cycles, mem_wdata=8'h3C, dt_done, rdata unchanged, mem_rd never 1.
//  3 Tie: if_req and dt_req high together, held across 3 transactions -> grants IF, DT, IF.
//    Each done is followed by exactly 1 IDLE cycle.
//  4 Timeout: dt_req read, mem_ready held 0 -> mem_rd high TIMEOUT cycles.
//    Then dt_done=1 and err=1 in the same cycle; rdata unchanged; next request served normally.
//  5 Reset mid-ACCESS: assert rst during mem_rd -> outputs 0 at once, no done.
//    After release with if_req=1 -> fresh 4-cycle fetch.
//  6 Dropped request: dt_req deasserted during ACCESS -> dt_done still pulses after mem_ready.
//    Stray mem_ready in IDLE causes no capture.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the RISC-SPM memory access controller.
// Holds FSM state codes and requester IDs used by the top and the arbiter.
// No logic; constants only.
package mem_access_ctrl_pkg;

  // FSM state encodings (IDLE -> LOAD -> ACCESS -> DONE -> IDLE)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Requester IDs; also the bit positions in the arbiter request vector
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DT = 1'b1;

endpackage

// File: rtl/mem_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, grants the requester that did not win last.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the grant is consumed.
module mem_access_ctrl_rr_arb2
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_vld_o,
  output logic       grant_o
);

  // Pick a single winner; the previous winner yields on a tie
  always_comb begin
    grant_vld_o = |req_i;
    grant_o     = REQ_IF;
    if (req_i == 2'b11) begin
      grant_o = ~last_grant_i;
    end else if (req_i[REQ_DT]) begin
      grant_o = REQ_DT;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the Address_Register load and the shared memory port for IF and DT requesters.
// Latency: request in IDLE at N -> ar_load N+1 -> strobe from N+2 -> done one cycle after mem_ready.
// Backpressure: requests are levels held until done; a timeout bounds the wait on mem_ready.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int TIMEOUT   = 15,
  parameter int TO_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  input  logic                 dt_req,
  input  logic                 dt_we,
  input  logic [WORD_SIZE-1:0] dt_addr,
  input  logic [WORD_SIZE-1:0] dt_wdata,
  output logic [WORD_SIZE-1:0] ar_data,
  output logic                 ar_load,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [WORD_SIZE-1:0] rdata,
  output logic                 if_done,
  output logic                 dt_done,
  output logic                 err
);

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 last_q, last_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;

  logic grant_vld;
  logic grant;
  logic is_wr;

  mem_access_ctrl_rr_arb2 u_arb (
    .req_i        ({dt_req, if_req}),
    .last_grant_i (last_q),
    .grant_vld_o  (grant_vld),
    .grant_o      (grant)
  );

  // Only a DT owner can write; we_q is cleared on IF grants, the owner term keeps that explicit
  assign is_wr = (owner_q == REQ_DT) && we_q;

  // Next-state logic: arbitration, timeout counting and read-data capture
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d = grant;
          we_d    = dt_we && (grant == REQ_DT);
          wdata_d = dt_wdata;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_ready) begin
          if (!is_wr) begin
            rdata_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without mem_ready: give up
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        cnt_d   = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset makes IF win the first tie by recording DT as last winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_IF;
      we_q    <= 1'b0;
      wdata_q <= '0;
      last_q  <= REQ_DT;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from registered state so reset clears them immediately
  assign ar_load   = (state_q == ST_LOAD);
  assign ar_data   = !ar_load ? '0 : ((owner_q == REQ_IF) ? if_addr : dt_addr);
  assign mem_rd    = (state_q == ST_ACCESS) && !is_wr;
  assign mem_wr    = (state_q == ST_ACCESS) && is_wr;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
  assign if_done   = (state_q == ST_DONE) && (owner_q == REQ_IF);
  assign dt_done   = (state_q == ST_DONE) && (owner_q == REQ_DT);
  assign err       = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reset, fetch, write, round robin, timeout, abort, dropped request.
// Inputs are driven 1ns after each rising edge and outputs are sampled at that same point.
// Expected values are hand-computed constants.
module tb_mem_access_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       if_req = 1'b0;
  logic [7:0] if_addr = 8'h00;
  logic       dt_req = 1'b0;
  logic       dt_we = 1'b0;
  logic [7:0] dt_addr = 8'h00;
  logic [7:0] dt_wdata = 8'h00;
  logic [7:0] ar_data;
  logic       ar_load;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] rdata;
  logic       if_done;
  logic       dt_done;
  logic       err;

  int tests = 0;
  int fails = 0;

  mem_access_ctrl #(.WORD_SIZE(8), .TIMEOUT(15), .TO_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .dt_req    (dt_req),
    .dt_we     (dt_we),
    .dt_addr   (dt_addr),
    .dt_wdata  (dt_wdata),
    .ar_data   (ar_data),
    .ar_load   (ar_load),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .if_done   (if_done),
    .dt_done   (dt_done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [47:0] obs;
    #12 rst = 1'b0;
    #1;
    obs = {ar_data, ar_load, mem_rd, mem_wr, mem_wdata, rdata, if_done, dt_done, err, 13'd0};
    tests++;
    if (obs !== 48'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h exp %h", obs, 48'd0);
    end
    step();
    rst = 1'b1;
    step();
    tests++;
    if ({ar_load, mem_rd, mem_wr, if_done, dt_done, err} !== 6'd0) begin
      fails++;
      $display("FAIL reset_idle got %b exp 000000", {ar_load, mem_rd, mem_wr, if_done, dt_done, err});
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 8'h10;
    step();
    tests++;
    if ({ar_load, ar_data, mem_rd} !== {1'b1, 8'h10, 1'b0}) begin
      fails++;
      $display("FAIL fetch_load got %b/%h/%b exp 1/10/0", ar_load, ar_data, mem_rd);
    end
    mem_ready = 1'b1; mem_rdata = 8'hAA;
    step();
    tests++;
    if ({mem_rd, mem_wr, ar_load, ar_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL fetch_access got rd=%b wr=%b ld=%b ad=%h exp 1 0 0 00", mem_rd, mem_wr, ar_load, ar_data);
    end
    step();
    tests++;
    if ({if_done, dt_done, err, mem_rd, rdata} !== {4'b1000, 8'hAA}) begin
      fails++;
      $display("FAIL fetch_done got if=%b dt=%b err=%b rd=%b rdata=%h exp 1 0 0 0 aa", if_done, dt_done, err, mem_rd, rdata);
    end
    if_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_dt_write();
    dt_req = 1'b1; dt_we = 1'b1; dt_addr = 8'h55; dt_wdata = 8'h3C;
    step();
    tests++;
    if ({ar_load, ar_data} !== {1'b1, 8'h55}) begin
      fails++;
      $display("FAIL wr_load got %b/%h exp 1/55", ar_load, ar_data);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({mem_wr, mem_rd, mem_wdata} !== {2'b10, 8'h3C}) begin
        fails++;
        $display("FAIL wr_access%0d got wr=%b rd=%b wdata=%h exp 1 0 3c", i, mem_wr, mem_rd, mem_wdata);
      end
      if (i == 3) mem_ready = 1'b1;
    end
    step();
    tests++;
    if ({dt_done, if_done, err, mem_wr, rdata} !== {4'b1000, 8'hAA}) begin
      fails++;
      $display("FAIL wr_done got dt=%b if=%b err=%b wr=%b rdata=%h exp 1 0 0 0 aa", dt_done, if_done, err, mem_wr, rdata);
    end
    dt_req = 1'b0; dt_we = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_tie();
    logic [7:0] exp_addr [3];
    logic [1:0] exp_done [3];
    exp_addr[0] = 8'h20; exp_addr[1] = 8'h30; exp_addr[2] = 8'h20;
    exp_done[0] = 2'b10; exp_done[1] = 2'b01; exp_done[2] = 2'b10;
    if_req = 1'b1; if_addr = 8'h20;
    dt_req = 1'b1; dt_we = 1'b0; dt_addr = 8'h30;
    mem_ready = 1'b1; mem_rdata = 8'h5A;
    for (int t = 0; t < 3; t++) begin
      step();
      tests++;
      if ({ar_load, ar_data} !== {1'b1, exp_addr[t]}) begin
        fails++;
        $display("FAIL tie_grant%0d got %b/%h exp 1/%h", t, ar_load, ar_data, exp_addr[t]);
      end
      step();
      step();
      tests++;
      if ({if_done, dt_done} !== exp_done[t]) begin
        fails++;
        $display("FAIL tie_done%0d got %b exp %b", t, {if_done, dt_done}, exp_done[t]);
      end
      if (t == 2) begin
        if_req = 1'b0; dt_req = 1'b0; mem_ready = 1'b0;
      end
      step();
      tests++;
      if ({ar_load, mem_rd, if_done, dt_done} !== 4'b0000) begin
        fails++;
        $display("FAIL tie_idle%0d got %b exp 0000", t, {ar_load, mem_rd, if_done, dt_done});
      end
    end
    tests++;
    if (rdata !== 8'h5A) begin
      fails++;
      $display("FAIL tie_rdata got %h exp 5a", rdata);
    end
  endtask

  task automatic test_timeout();
    int rd_cnt = 0;
    bit seen = 1'b0;
    dt_req = 1'b1; dt_we = 1'b0; dt_addr = 8'h40; mem_rdata = 8'hEE;
    step();
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (mem_rd) rd_cnt++;
      if (dt_done) begin
        seen = 1'b1;
        tests++;
        if ({err, if_done, rdata} !== {2'b10, 8'h5A}) begin
          fails++;
          $display("FAIL to_done got err=%b if=%b rdata=%h exp 1 0 5a", err, if_done, rdata);
        end
      end
    end
    tests++;
    if (!seen || rd_cnt != 15) begin
      fails++;
      $display("FAIL to_cycles got done=%0d rd_cycles=%0d exp 1 15", seen, rd_cnt);
    end
    dt_req = 1'b0;
    step();
    if_req = 1'b1; if_addr = 8'h11; mem_ready = 1'b1; mem_rdata = 8'h77;
    step(); step(); step();
    tests++;
    if ({if_done, err, rdata} !== {2'b10, 8'h77}) begin
      fails++;
      $display("FAIL to_recover got if=%b err=%b rdata=%h exp 1 0 77", if_done, err, rdata);
    end
    if_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    dt_req = 1'b1; dt_we = 1'b1; dt_addr = 8'h01; dt_wdata = 8'h99;
    step(); step();
    dt_req = 1'b0; dt_we = 1'b0;
    if_req = 1'b1; if_addr = 8'h12;
    tests++;
    if (mem_wr !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_pre got wr=%b exp 1", mem_wr);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({mem_rd, mem_wr, ar_load, dt_done, if_done, err, mem_wdata, rdata} !== 14'd0) begin
      fails++;
      $display("FAIL rstmid_zero got wr=%b wdata=%h rdata=%h dn=%b exp 0 00 00 0", mem_wr, mem_wdata, rdata, dt_done);
    end
    @(posedge clk);
    #1 saw_done = if_done | dt_done | err;
    #7 rst = 1'b1;
    mem_ready = 1'b1; mem_rdata = 8'h4B;
    step();
    tests++;
    if ({saw_done, ar_load, ar_data} !== {2'b01, 8'h12}) begin
      fails++;
      $display("FAIL rstmid_load got done=%b ld=%b ad=%h exp 0 1 12", saw_done, ar_load, ar_data);
    end
    step();
    step();
    tests++;
    if ({if_done, dt_done, rdata} !== {2'b10, 8'h4B}) begin
      fails++;
      $display("FAIL rstmid_fetch got if=%b dt=%b rdata=%h exp 1 0 4b", if_done, dt_done, rdata);
    end
    if_req = 1'b0; mem_ready = 1'b0;
    step();
  endtask

  task automatic test_dropped();
    dt_req = 1'b1; dt_we = 1'b0; dt_addr = 8'h66;
    step(); step();
    dt_req = 1'b0;
    step();
    mem_ready = 1'b1; mem_rdata = 8'hC3;
    step();
    tests++;
    if ({dt_done, if_done, rdata} !== {2'b10, 8'hC3}) begin
      fails++;
      $display("FAIL drop_done got dt=%b if=%b rdata=%h exp 1 0 c3", dt_done, if_done, rdata);
    end
    mem_ready = 1'b0;
    step();
    mem_ready = 1'b1; mem_rdata = 8'h99;
    step(); step();
    tests++;
    if ({rdata, ar_load, mem_rd, dt_done} !== {8'hC3, 3'b000}) begin
      fails++;
      $display("FAIL stray_ready got rdata=%h ld=%b rd=%b exp c3 0 0", rdata, ar_load, mem_rd);
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_dt_write();
    test_tie();
    test_timeout();
    test_reset_mid();
    test_dropped();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
